// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives a JK flip-flop bank to target words and verifies the settled Q
// Optional JK_DRV_SHADOW_RESYNC_EN: on a failed compare the shadow state is reloaded from q_fb.
module jk_excitation_driver #(
   parameter int unsigned  W          = 8,
   parameter logic [W-1:0] INIT_Q     = '0,
   parameter int unsigned  DC_POLICY  = 0,
   parameter int unsigned  SETTLE_CYC = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] tgt_data,
   input  logic         tgt_valid,
   output logic         tgt_ready,
   output logic [W-1:0] j,
   output logic [W-1:0] k,
   input  logic [W-1:0] q_fb,
   output logic         busy,
   output logic         done,
   output logic         mismatch
);

   typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   state_t       state;
   state_t       state_nxt;
   logic [W-1:0] shadow;
   logic [W-1:0] tgt_r;
   logic [3:0]   cnt;
   logic         ready_r;
   logic         accept;
   logic [W-1:0] up;
   logic [W-1:0] dn;
   logic [W-1:0] j_exc;
   logic [W-1:0] k_exc;

   // ready_r keeps tgt_ready low for the cycle right after a reset edge
   assign tgt_ready = (state == IDLE) && ready_r;
   assign busy      = (state != IDLE);
   assign accept    = tgt_valid && tgt_ready;

   always_comb begin
      up = ~shadow & tgt_data;
      dn = shadow & ~tgt_data;
      if (DC_POLICY == 0) begin
         j_exc = up;
         k_exc = dn;
      end else begin
         j_exc = up | dn;
         k_exc = up | dn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = DRIVE;
         DRIVE:   state_nxt = SETTLE;
         SETTLE:  if (cnt == 4'd0) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow   <= INIT_Q;
         tgt_r    <= '0;
         j        <= '0;
         k        <= '0;
         cnt      <= '0;
         ready_r  <= 1'b0;
         done     <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         ready_r <= 1'b1;
         done    <= 1'b0;
         j       <= '0;
         k       <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  tgt_r    <= tgt_data;
                  j        <= j_exc;
                  k        <= k_exc;
                  mismatch <= 1'b0;
               end
            end
            DRIVE: begin
               // the bank captures at this edge, so the shadow follows it here
               shadow <= tgt_r;
               cnt    <= SETTLE_LOAD;
            end
            SETTLE: begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
            end
            CHECK: begin
               mismatch <= (q_fb != tgt_r);
               done     <= 1'b1;
`ifdef JK_DRV_SHADOW_RESYNC_EN
               if (q_fb != tgt_r) shadow <= q_fb;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - bench for jk_excitation_driver with JK bank models and scoreboards
module tb_jk_excitation_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] tgt_data_a, j_a, k_a, q_fb_a, bank_a, stuck_a;
   logic       tgt_valid_a, tgt_ready_a, busy_a, done_a, mismatch_a;
   logic [7:0] tgt_data_b, j_b, k_b, q_fb_b, bank_b;
   logic       tgt_valid_b, tgt_ready_b, busy_b, done_b, mismatch_b;

   int checks = 0;
   int errors = 0;

   jk_excitation_driver #(.W(8), .INIT_Q(8'h00), .DC_POLICY(0), .SETTLE_CYC(1)) dut_a (
      .clk(clk), .rst(rst), .tgt_data(tgt_data_a), .tgt_valid(tgt_valid_a),
      .tgt_ready(tgt_ready_a), .j(j_a), .k(k_a), .q_fb(q_fb_a),
      .busy(busy_a), .done(done_a), .mismatch(mismatch_a));

   jk_excitation_driver #(.W(8), .INIT_Q(8'h00), .DC_POLICY(1), .SETTLE_CYC(3)) dut_b (
      .clk(clk), .rst(rst), .tgt_data(tgt_data_b), .tgt_valid(tgt_valid_b),
      .tgt_ready(tgt_ready_b), .j(j_b), .k(k_b), .q_fb(q_fb_b),
      .busy(busy_b), .done(done_b), .mismatch(mismatch_b));

   function automatic logic [7:0] jk_apply(input logic [7:0] q, input logic [7:0] jj, input logic [7:0] kk);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         case ({jj[i], kk[i]})
            2'b01:   r[i] = 1'b0;
            2'b10:   r[i] = 1'b1;
            2'b11:   r[i] = ~q[i];
            default: r[i] = q[i];
         endcase
      end
      return r;
   endfunction

   function automatic logic [15:0] excite(input logic [7:0] cur, input logic [7:0] nxt, input int dc);
      logic [7:0] jj;
      logic [7:0] kk;
      jj = 8'h00;
      kk = 8'h00;
      for (int i = 0; i < 8; i++) begin
         case ({cur[i], nxt[i]})
            2'b01: begin jj[i] = 1'b1; kk[i] = (dc == 1); end
            2'b10: begin kk[i] = 1'b1; jj[i] = (dc == 1); end
            default: ;
         endcase
      end
      return {jj, kk};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // JK banks sharing the DUT clock; bit errors on A are injected on the feedback path only
   always @(posedge clk) begin
      if (rst) begin
         bank_a <= 8'h00;
         bank_b <= 8'h00;
      end else begin
         bank_a <= jk_apply(bank_a, j_a, k_a);
         bank_b <= jk_apply(bank_b, j_b, k_b);
      end
   end
   assign q_fb_a = bank_a & ~stuck_a;
   assign q_fb_b = bank_b;

   logic [15:0] jk_q_a[$];
   logic        mm_q_a[$];
   logic [15:0] jk_q_b[$];
   logic        mm_q_b[$];
   logic [7:0]  m_shadow_a, m_bank_a, m_shadow_b, m_bank_b;
   logic        chk_a, chk_b;

   always @(posedge clk) begin
      logic [15:0] e;
      logic [7:0]  fb;
      logic        mm;
      chk_a = 1'b0;
      chk_b = 1'b0;
      if (rst) begin
         jk_q_a.delete(); mm_q_a.delete(); jk_q_b.delete(); mm_q_b.delete();
         m_shadow_a = 8'h00; m_bank_a = 8'h00; m_shadow_b = 8'h00; m_bank_b = 8'h00;
      end else begin
         if (tgt_valid_a && tgt_ready_a) begin
            e = excite(m_shadow_a, tgt_data_a, 0);
            jk_q_a.push_back(e);
            chk_a = 1'b1;
            m_bank_a = jk_apply(m_bank_a, e[15:8], e[7:0]);
            fb = m_bank_a & ~stuck_a;
            mm = (fb != tgt_data_a);
            mm_q_a.push_back(mm);
            m_shadow_a = tgt_data_a;
`ifdef JK_DRV_SHADOW_RESYNC_EN
            if (mm) m_shadow_a = fb;
`endif
         end
         if (tgt_valid_b && tgt_ready_b) begin
            e = excite(m_shadow_b, tgt_data_b, 1);
            jk_q_b.push_back(e);
            chk_b = 1'b1;
            m_bank_b = jk_apply(m_bank_b, e[15:8], e[7:0]);
            mm = (m_bank_b != tgt_data_b);
            mm_q_b.push_back(mm);
            m_shadow_b = tgt_data_b;
`ifdef JK_DRV_SHADOW_RESYNC_EN
            if (mm) m_shadow_b = m_bank_b;
`endif
         end
      end
   end

   always @(negedge clk) begin
      logic [15:0] e;
      if (chk_a && jk_q_a.size() > 0) begin
         e = jk_q_a.pop_front();
         check("sb_a_j", j_a, e[15:8]);
         check("sb_a_k", k_a, e[7:0]);
         check("sb_a_jk_exclusive", j_a & k_a, 8'h00);
      end
      if (chk_b && jk_q_b.size() > 0) begin
         e = jk_q_b.pop_front();
         check("sb_b_j", j_b, e[15:8]);
         check("sb_b_k", k_b, e[7:0]);
      end
      if (done_a) begin
         check("sb_a_done_expected", mm_q_a.size() > 0, 1);
         if (mm_q_a.size() > 0) check("sb_a_mismatch", mismatch_a, mm_q_a.pop_front());
      end
      if (done_b) begin
         check("sb_b_done_expected", mm_q_b.size() > 0, 1);
         if (mm_q_b.size() > 0) check("sb_b_mismatch", mismatch_b, mm_q_b.pop_front());
      end
   end

   task automatic set_in(input int sel, input logic [7:0] d, input logic v);
      if (sel == 0) begin tgt_data_a = d; tgt_valid_a = v; end
      else          begin tgt_data_b = d; tgt_valid_b = v; end
   endtask

   function automatic logic rdy(input int sel);
      return (sel == 0) ? tgt_ready_a : tgt_ready_b;
   endfunction

   function automatic logic dn(input int sel);
      return (sel == 0) ? done_a : done_b;
   endfunction

   task automatic send(input int sel, input logic [7:0] d, input logic [7:0] ej, input logic [7:0] ek,
                       input int lat, input logic emm, input string tag);
      int n;
      @(negedge clk);
      set_in(sel, d, 1'b1);
      n = 0;
      while (!rdy(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, rdy(sel), 1);
      @(negedge clk);
      set_in(sel, 8'h00, 1'b0);
      check({tag, "_j"}, (sel == 0) ? j_a : j_b, ej);
      check({tag, "_k"}, (sel == 0) ? k_a : k_b, ek);
      n = 1;
      while (!dn(sel) && n < 30) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_mismatch"}, (sel == 0) ? mismatch_a : mismatch_b, emm);
      check({tag, "_ready_on_done"}, rdy(sel), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      int dones;
      rst = 1'b1;
      stuck_a = 8'h00;
      set_in(0, 8'h00, 1'b0);
      set_in(1, 8'h00, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("rst_ready", tgt_ready_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_j", j_a, 8'h00);
      check("rst_k", k_a, 8'h00);
      check("rst_done", done_a, 0);
      check("rst_mismatch", mismatch_a, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", tgt_ready_a, 1);

      send(0, 8'hA5, 8'hA5, 8'h00, 4, 1'b0, "t1");
      check("t1_bank_q", q_fb_a, 8'hA5);
      send(0, 8'h5A, 8'h5A, 8'hA5, 4, 1'b0, "t2");

      // back-to-back with tgt_valid held high across the whole first transaction
      @(negedge clk);
      set_in(0, 8'hA5, 1'b1);
      @(negedge clk);
      check("t3_first_j", j_a, 8'hA5);
      check("t3_first_k", k_a, 8'h5A);
      n = 1;
      while (!done_a && n < 30) begin @(negedge clk); n++; end
      check("t3_first_latency", n, 4);
      check("t3_ready_on_done", tgt_ready_a, 1);
      @(negedge clk);
      set_in(0, 8'h00, 1'b0);
      check("t3_no_gap_busy", busy_a, 1);
      check("t3_second_j", j_a, 8'h00);
      check("t3_second_k", k_a, 8'h00);
      n = 1;
      while (!done_a && n < 30) begin @(negedge clk); n++; end
      check("t3_second_latency", n, 4);
      check("t3_second_mismatch", mismatch_a, 0);

      // feedback bit 0 stuck low
      @(negedge clk);
      stuck_a = 8'h01;
      send(0, 8'h01, 8'h00, 8'hA4, 4, 1'b1, "t4a");
`ifdef JK_DRV_SHADOW_RESYNC_EN
      send(0, 8'h00, 8'h00, 8'h00, 4, 1'b0, "t4b");
`else
      send(0, 8'h00, 8'h00, 8'h01, 4, 1'b0, "t4b");
`endif
      @(negedge clk);
      stuck_a = 8'h00;

      // reset while in SETTLE
      @(negedge clk);
      set_in(0, 8'hA5, 1'b1);
      @(negedge clk);
      set_in(0, 8'h00, 1'b0);
      check("t5_drive_j", j_a, 8'hA5);
      @(negedge clk);
      check("t5_in_settle", busy_a, 1);
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy", busy_a, 0);
      check("t5_j", j_a, 8'h00);
      check("t5_k", k_a, 8'h00);
      check("t5_done", done_a, 0);
      check("t5_ready_low", tgt_ready_a, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_ready_high", tgt_ready_a, 1);
      check("t5_done_after", done_a, 0);
      send(0, 8'h3C, 8'h3C, 8'h00, 4, 1'b0, "t5b");

      // SETTLE_CYC=3, toggle-style fill; valid pulses while busy must be ignored
      @(negedge clk);
      set_in(1, 8'hFF, 1'b1);
      @(negedge clk);
      set_in(1, 8'h00, 1'b0);
      check("t6_j", j_b, 8'hFF);
      check("t6_k", k_b, 8'hFF);
      dones = 0;
      n = 0;
      for (int c = 2; c <= 12; c++) begin
         @(negedge clk);
         set_in(1, 8'h3C, (c == 2 || c == 4));
         if (done_b) begin
            dones++;
            if (n == 0) n = c;
         end
      end
      set_in(1, 8'h00, 1'b0);
      check("t6_latency", n, 6);
      check("t6_single_done", dones, 1);
      check("t6_bank_q", q_fb_b, 8'hFF);
      send(1, 8'hA5, 8'h5A, 8'h5A, 6, 1'b0, "t2b_a");
      send(1, 8'h5A, 8'hFF, 8'hFF, 6, 1'b0, "t2b_b");

      repeat (3) @(negedge clk);
      check("end_queue_a", mm_q_a.size(), 0);
      check("end_queue_b", mm_q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives a W-bit bank of JK flip-flops, all on the same `clk`, toward target words.
- Targets arrive through a valid/ready handshake.
- For each target, the block derives the per-bit J/K excitation from a shadow copy of the bank's present state and drives it for exactly one clock.
- It then waits for the bank outputs to settle, compares the fed-back Q against the target, and reports done and mismatch.

Parameters:
- W, 8, number of JK flip-flops driven; each bit has its own J, K and Q feedback.
- INIT_Q, 0 (W bits), shadow-state reset value; must equal the bank's power-up Q (bank reset Q=0).
- DC_POLICY, 0, don't-care fill: 0 = hold-style (no toggles), 1 = toggle-style (J=K=1 on every change).
- SETTLE_CYC, 1, number of cycles after the bank's capture edge before q_fb is compared; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock shared with the JK bank
- rst  input  1  synchronous, active-high reset
- tgt_data  input  W  requested next bank state
- tgt_valid  input  1  tgt_data valid
- tgt_ready  output  1  block can accept a target
- j  output  W  J excitation to the bank (registered)
- k  output  W  K excitation to the bank (registered)
- q_fb  input  W  bank Q outputs
- busy  output  1  a transaction is in flight
- done  output  1  one-cycle pulse: comparison completed
- mismatch  output  1  result of the last comparison; sticky until the next accept

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - state=IDLE, shadow=INIT_Q, j=0, k=0.
  - tgt_ready=0 during the reset cycle, 1 from the following cycle.
  - busy=0, done=0, mismatch=0, settle counter=0.
- Reset overrides everything; asserting it mid-transaction aborts immediately: no done pulse, and the shadow returns to INIT_Q.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - tgt_ready=1, busy=0, j=k=0.
  - Accept on tgt_valid&&tgt_ready at edge E0. At E0: latch tgt_data into tgt_r, load j/k from the excitation table, clear mismatch, go to DRIVE.
- Excitation table, per bit (cur=shadow[i], nxt=tgt_data[i]):
  - 0->0: J=0, K=0.
  - 1->1: J=0, K=0.
  - 0->1: DC_POLICY=0 gives J=1, K=0; DC_POLICY=1 gives J=1, K=1.
  - 1->0: DC_POLICY=0 gives J=0, K=1; DC_POLICY=1 gives J=1, K=1.
- DRIVE (exactly one cycle, E0..E1):
  - j/k hold the excitation; the bank captures at E1.
  - At E1: j=k=0 (bank holds), shadow<=tgt_r, counter<=SETTLE_CYC-1, go to SETTLE.
- SETTLE: counter decrements each cycle; when counter==0, go to CHECK at that edge.
- CHECK (one cycle):
  - At its closing edge, mismatch<=(q_fb!=tgt_r).
  - done=1 for the cycle following that edge; go to IDLE.
- Latency: with SETTLE_CYC=1, accept at E0 gives done high in the cycle after E3, and tgt_ready high again in that same cycle.
- Back-to-back: a new target may be accepted in the same cycle done is high.
- busy=1 and tgt_ready=0 in DRIVE, SETTLE and CHECK. tgt_valid is ignored while busy; tgt_data need not stay stable after accept.
- Target equal to shadow: all j=k=0; the transaction still runs fully and produces done.
- j and k are never both 1 on any bit when DC_POLICY=0.

Optional Feature:
- Macro: JK_DRV_SHADOW_RESYNC_EN.
- Defined: in CHECK, if a mismatch is detected, shadow<=q_fb at the same edge, so the next excitation is computed from the real bank state.
- Undefined: shadow keeps tgt_r regardless of the comparison result. mismatch reporting is identical in both cases.

Test Plan:
1. Reset with W=8, INIT_Q=0, DC_POLICY=0; send 8'hA5 -> during DRIVE j=8'hA5, k=8'h00; bank Q=8'hA5; done pulses 4 cycles after accept; mismatch=0.
2. From 8'hA5, send 8'h5A -> j=8'h5A, k=8'hA5; mismatch=0. Repeat with DC_POLICY=1 -> j=k=8'hFF.
3. Send 8'hA5 twice back-to-back, tgt_valid held high -> second accept in the cycle done is high; second transaction has j=k=8'h00; no idle gap between transactions.
4. Force q_fb bit 0 stuck at 0; send 8'h01 -> mismatch=1 with done. Then send 8'h00: with the macro, j=k=8'h00 (shadow resynced to 8'h00); without it, k=8'h01 (shadow still 8'h01).
5. Assert rst during SETTLE -> next cycle busy=0, j=k=0, no done pulse, tgt_ready=1 one cycle after rst deasserts; next target's excitation is computed from shadow 8'h00.
6. SETTLE_CYC=3; send 8'hFF from 8'h00 -> done occurs 6 cycles after accept; tgt_valid pulses while busy are ignored (exactly one done).
